// File: rtl/collision_detector.sv
// Per-frame sprite/obstacle collision and finish-line detector. It scans the obstacle table serially through a 1-cycle-latency read port.
// Optional feature: define COLLISION_COUNT_EN to add a saturating collision_count output.
module collision_detector #(
  parameter int COORD_W       = 10,
  parameter int MAX_OBS       = 6,
  parameter int OBS_PER_LEVEL = 2,
  parameter int BALL_SIZE     = 8,
  parameter int OBS_SIZE      = 16,
  parameter int FINISH_X      = 600
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       abort,
  input  logic [COORD_W-1:0]         ball_x,
  input  logic [COORD_W-1:0]         ball_y,
  input  logic [1:0]                 obstacle_count,
  output logic                       obs_rd_en,
  output logic [$clog2(MAX_OBS)-1:0] obs_addr,
  input  logic [COORD_W-1:0]         obs_x,
  input  logic [COORD_W-1:0]         obs_y,
  output logic                       busy,
  output logic                       sprite_collision,
  output logic                       finish_line_reached,
`ifdef COLLISION_COUNT_EN
  output logic [7:0]                 collision_count,
`endif
  output logic [$clog2(MAX_OBS)-1:0] collide_index
);

  localparam int IDX_W = $clog2(MAX_OBS);
  localparam int CNT_W = $clog2(MAX_OBS + 1);
  localparam int EXT_W = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, READ, CHECK, REPORT} state_e;

  function automatic logic [CNT_W-1:0] active_count(input logic [1:0] cnt);
    int prod;
    prod = int'(cnt) * OBS_PER_LEVEL;
    if (prod > MAX_OBS) prod = MAX_OBS;
    return CNT_W'(prod);
  endfunction

  // Strict inequalities: boxes that only share an edge do not collide.
  function automatic logic boxes_overlap(input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                                         input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy);
    logic [EXT_W-1:0] bx_e, by_e, ox_e, oy_e;
    bx_e = {1'b0, bx};
    by_e = {1'b0, by};
    ox_e = {1'b0, ox};
    oy_e = {1'b0, oy};
    return (bx_e < ox_e + EXT_W'(OBS_SIZE))  && (ox_e < bx_e + EXT_W'(BALL_SIZE)) &&
           (by_e < oy_e + EXT_W'(OBS_SIZE))  && (oy_e < by_e + EXT_W'(BALL_SIZE));
  endfunction

  function automatic logic finish_hit(input logic [COORD_W-1:0] bx);
    return ({1'b0, bx} + EXT_W'(BALL_SIZE)) >= EXT_W'(FINISH_X);
  endfunction

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   active_q, active_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [IDX_W-1:0]   collide_index_q, collide_index_d;
  logic               obs_rd_en_q, obs_rd_en_d;
  logic [IDX_W-1:0]   obs_addr_q, obs_addr_d;
  logic               busy_q, busy_d;
  logic               sprite_q, sprite_d;
  logic               finish_q, finish_d;
  logic [COORD_W-1:0] snap_x_q, snap_x_d;
  logic [COORD_W-1:0] snap_y_q, snap_y_d;
  logic               accept;
`ifdef COLLISION_COUNT_EN
  logic [7:0]         count_q, count_d;
`endif

  // A frame_start is accepted only from an idle FSM with no start already pending; abort wins.
  assign accept = frame_start && !abort && (state_q == IDLE) && !start_q;

  always_comb begin
    state_d         = state_q;
    start_d         = accept;
    idx_d           = idx_q;
    active_d        = accept ? active_count(obstacle_count) : active_q;
    hit_d           = hit_q;
    hit_idx_d       = hit_idx_q;
    collide_index_d = collide_index_q;
    snap_x_d        = accept ? ball_x : snap_x_q;
    snap_y_d        = accept ? ball_y : snap_y_q;
`ifdef COLLISION_COUNT_EN
    count_d         = count_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_q) begin
          idx_d   = '0;
          hit_d   = 1'b0;
          state_d = (active_q != '0) ? READ : REPORT;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        // Table data for idx_q arrives this cycle, one cycle after the READ strobe.
        if (!hit_q && boxes_overlap(snap_x_q, snap_y_q, obs_x, obs_y)) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
        end
        if (int'(idx_q) == int'(active_q) - 1) begin
          state_d = REPORT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = READ;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      start_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with the FSM state.
    busy_d      = (state_d != IDLE);
    obs_rd_en_d = (state_d == READ);
    obs_addr_d  = (state_d == READ) ? idx_d : '0;
    sprite_d    = (state_d == REPORT) && hit_d;
    finish_d    = (state_d == REPORT) && !hit_d && finish_hit(snap_x_q);
    if ((state_d == REPORT) && hit_d) begin
      collide_index_d = hit_idx_d;
`ifdef COLLISION_COUNT_EN
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      start_q         <= 1'b0;
      idx_q           <= '0;
      active_q        <= '0;
      hit_q           <= 1'b0;
      hit_idx_q       <= '0;
      collide_index_q <= '0;
      obs_rd_en_q     <= 1'b0;
      obs_addr_q      <= '0;
      busy_q          <= 1'b0;
      sprite_q        <= 1'b0;
      finish_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_q         <= start_d;
      idx_q           <= idx_d;
      active_q        <= active_d;
      hit_q           <= hit_d;
      hit_idx_q       <= hit_idx_d;
      collide_index_q <= collide_index_d;
      obs_rd_en_q     <= obs_rd_en_d;
      obs_addr_q      <= obs_addr_d;
      busy_q          <= busy_d;
      sprite_q        <= sprite_d;
      finish_q        <= finish_d;
    end
  end

  // Position snapshot is pure data and is always written before it is used.
  always_ff @(posedge clk) begin
    snap_x_q <= snap_x_d;
    snap_y_q <= snap_y_d;
  end

`ifdef COLLISION_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end
  assign collision_count = count_q;
`endif

  assign obs_rd_en           = obs_rd_en_q;
  assign obs_addr            = obs_addr_q;
  assign busy                = busy_q;
  assign sprite_collision    = sprite_q;
  assign finish_line_reached = finish_q;
  assign collide_index       = collide_index_q;

endmodule

// File: tb/tb_collision_detector.sv
// Testbench for collision_detector: directed and randomized frames against a behavioural model.
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic [1:0] obstacle_count = '0;
  logic       obs_rd_en;
  logic [2:0] obs_addr;
  logic [9:0] obs_x = '0;
  logic [9:0] obs_y = '0;
  logic       busy;
  logic       sprite_collision;
  logic       finish_line_reached;
  logic [2:0] collide_index;
`ifdef COLLISION_COUNT_EN
  logic [7:0] collision_count;
`endif

  int compared = 0;
  int mismatched = 0;
  int exp_ci = 0;
  int exp_cnt = 0;
  logic [9:0] tbl_x [0:7];
  logic [9:0] tbl_y [0:7];

  collision_detector dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
    .ball_x(ball_x), .ball_y(ball_y), .obstacle_count(obstacle_count),
    .obs_rd_en(obs_rd_en), .obs_addr(obs_addr), .obs_x(obs_x), .obs_y(obs_y),
    .busy(busy), .sprite_collision(sprite_collision),
    .finish_line_reached(finish_line_reached),
`ifdef COLLISION_COUNT_EN
    .collision_count(collision_count),
`endif
    .collide_index(collide_index)
  );

  always #5 clk = ~clk;

  // Obstacle table with one cycle of read latency.
  always @(posedge clk) begin
    if (obs_rd_en) begin
      obs_x <= tbl_x[obs_addr];
      obs_y <= tbl_y[obs_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int bx, input int by, input int cnt,
                                output int act, output bit col, output int idx, output bit fin);
    int tx, ty;
    act = cnt * 2;
    if (act > 6) act = 6;
    col = 0;
    idx = 0;
    for (int i = 0; i < act; i++) begin
      tx = int'(tbl_x[i]);
      ty = int'(tbl_y[i]);
      if (!col && bx < tx + 16 && tx < bx + 8 && by < ty + 16 && ty < by + 8) begin
        col = 1;
        idx = i;
      end
    end
    fin = !col && (bx + 8 >= 600);
  endfunction

  // abort_k > 0: abort is sampled at the edge after observation point abort_k.
  // fs_k > 0: an extra frame_start is sampled at edge fs_k while the scan runs.
  task automatic run_frame(input int bx, input int by, input int cnt, input int abort_k, input int fs_k);
    int act, idx, lat, busy_last, sp_n, fi_n, sp_k, fi_k;
    bit col, fin, aborted;
    int reads[$];
    model(bx, by, cnt, act, col, idx, fin);
    lat = 1 + 2 * act;
    aborted = (abort_k > 0) && (abort_k < lat);
    busy_last = 0; sp_n = 0; fi_n = 0; sp_k = -1; fi_k = -1;
    @(negedge clk);
    ball_x = 10'(bx); ball_y = 10'(by); obstacle_count = 2'(cnt); frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) obstacle_count = 2'($urandom_range(0, 3));
      abort = (abort_k > 0) && (k == abort_k + 1);
      frame_start = (fs_k > 0) && (k == fs_k);
      @(negedge clk);
      if (busy) busy_last = k;
      if (obs_rd_en) reads.push_back(int'(obs_addr));
      if (sprite_collision) begin sp_n++; sp_k = k; end
      if (finish_line_reached) begin fi_n++; fi_k = k; end
    end
    abort = 1'b0;
    frame_start = 1'b0;
    if (aborted) begin
      check("abort_busy_end", busy_last, abort_k);
      check("abort_reads", reads.size(), (abort_k + 1) / 2);
      check("abort_no_sprite", sp_n, 0);
      check("abort_no_finish", fi_n, 0);
    end else begin
      check("busy_end", busy_last, lat);
      check("reads", reads.size(), act);
      check("sprite_pulses", sp_n, col ? 1 : 0);
      check("finish_pulses", fi_n, fin ? 1 : 0);
      if (col) check("sprite_latency", sp_k, lat);
      if (fin) check("finish_latency", fi_k, lat);
      if (col) begin
        exp_ci = idx;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    for (int i = 0; i < reads.size() && i < act; i++) check("read_addr", reads[i], i);
    check("collide_index", collide_index, exp_ci);
`ifdef COLLISION_COUNT_EN
    check("collision_count", collision_count, exp_cnt);
`endif
  endtask

  initial begin
    int j, bx, by;
    for (int i = 0; i < 8; i++) begin
      tbl_x[i] = 10'(400 + 40 * i);
      tbl_y[i] = 10'(0);
    end
    tbl_x[0] = 10'd100; tbl_y[0] = 10'd100;
    tbl_x[1] = 10'd300; tbl_y[1] = 10'd300;
    tbl_x[2] = 10'd590; tbl_y[2] = 10'd200;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", obs_rd_en, 0);
    check("rst_addr", obs_addr, 0);
    check("rst_sprite", sprite_collision, 0);
    check("rst_finish", finish_line_reached, 0);
    check("rst_ci", collide_index, 0);
`ifdef COLLISION_COUNT_EN
    check("rst_count", collision_count, 0);
`endif
    reset = 1'b0;

    // Directed frames
    run_frame(110, 105, 1, 0, 0);
    run_frame(92, 100, 1, 0, 0);
    run_frame(93, 100, 1, 0, 0);
    run_frame(592, 50, 0, 0, 0);
    run_frame(591, 50, 0, 0, 0);
    run_frame(595, 205, 2, 0, 0);
    run_frame(110, 105, 3, 6, 0);
    run_frame(595, 205, 3, 0, 3);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < 6; i++) begin
          tbl_x[i] = 10'($urandom_range(20, 600));
          tbl_y[i] = 10'($urandom_range(20, 450));
        end
      end
      j = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        bx = $urandom_range(570, 620);
        by = $urandom_range(0, 500);
      end else begin
        bx = int'(tbl_x[j]) + $urandom_range(0, 34) - 17;
        by = int'(tbl_y[j]) + $urandom_range(0, 34) - 17;
      end
      run_frame(bx, by, $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0, 0);
    end

`ifdef COLLISION_COUNT_EN
    tbl_x[0] = 10'd100; tbl_y[0] = 10'd100;
    for (int n = 0; n < 300; n++) run_frame(110, 105, 1, 0, 0);
    check("count_saturated", collision_count, 255);
    run_frame(110, 105, 3, 2, 0);
    check("count_after_abort", collision_count, 255);
`endif

    // Reset in the middle of a scan
    @(negedge clk);
    ball_x = 10'd110; ball_y = 10'd105; obstacle_count = 2'd3; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", obs_rd_en, 0);
    check("midrst_ci", collide_index, 0);
`ifdef COLLISION_COUNT_EN
    check("midrst_count", collision_count, 0);
`endif
    exp_ci = 0;
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(595, 205, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Per-frame event detector feeding the level/game controller; produces its sprite_collision and finish_line_reached inputs.
- On each frame_start it snapshots the player sprite position and serially scans the active obstacle table through a 1-cycle-latency read port.
- Runs an axis-aligned bounding-box overlap test per obstacle and a finish-line test, then reports both results as one-cycle pulses.

Parameters:
- COORD_W, 10, coordinate width in pixels.
- MAX_OBS, 6, obstacle table depth.
- OBS_PER_LEVEL, 2, obstacles enabled per unit of obstacle_count.
- BALL_SIZE, 8, sprite width/height in pixels.
- OBS_SIZE, 16, obstacle width/height in pixels.
- FINISH_X, 600, finish line x coordinate.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- abort  in  1  level reset from controller; cancels any scan in progress
- ball_x  in  COORD_W  sprite left edge
- ball_y  in  COORD_W  sprite top edge
- obstacle_count  in  2  level multiplier, 0..3
- obs_rd_en  out  1  table read strobe
- obs_addr  out  clog2(MAX_OBS)  table read address
- obs_x  in  COORD_W  obstacle left edge, valid the cycle after obs_rd_en
- obs_y  in  COORD_W  obstacle top edge, valid the cycle after obs_rd_en
- busy  out  1  scan in progress
- sprite_collision  out  1  one-cycle result pulse
- finish_line_reached  out  1  one-cycle result pulse
- collide_index  out  clog2(MAX_OBS)  lowest-index obstacle hit in the last scan

Behaviour:
- Clock and reset: clk; reset asynchronous, active-high.
- Reset values:
  - state IDLE
  - all outputs 0
  - idx 0, hit 0, collide_index 0
- Active count: active = min(obstacle_count*OBS_PER_LEVEL, MAX_OBS).
  - Sampled at frame_start; held for the whole scan.
- States:
  - IDLE: busy=0. On frame_start, snapshot ball_x/ball_y, clear idx and hit. Go to READ if active>0, else REPORT.
  - READ: obs_rd_en=1, obs_addr=idx. Go to CHECK.
  - CHECK: compare obs_x/obs_y against the snapshot.
    - On overlap with hit=0: set hit=1, collide_index=idx.
    - If idx==active-1, go to REPORT; else idx+1 and go to READ.
  - REPORT: go to IDLE next cycle. sprite_collision=hit; finish_line_reached=!hit && finish.
- Outputs:
  - Registered; asserted exactly the one cycle the FSM is in REPORT.
  - obs_rd_en is 0 outside READ.
  - busy=1 in READ, CHECK and REPORT.
- Latency: frame_start sampled at edge N puts the FSM in REPORT at edge N+1+2*active (active=0 gives N+1).
- Overlap test: all four strict conditions must hold; evaluate at COORD_W+1 bits so the sums never wrap:
  - ball_x < obs_x+OBS_SIZE
  - obs_x < ball_x+BALL_SIZE
  - ball_y < obs_y+OBS_SIZE
  - obs_y < ball_y+BALL_SIZE
- Edge-touching (equality) is not a collision.
- Finish test: snapshot ball_x+BALL_SIZE >= FINISH_X, at COORD_W+1 bits.
- Priority: collision suppresses finish within a frame, so the two pulses are never both high.
- Boundary cases:
  - frame_start while busy: ignored, no restart.
  - abort in any state: go to IDLE next edge, no pulse, collide_index unchanged. abort wins over a simultaneous frame_start.
  - obstacle_count change mid-scan: no effect until the next frame_start.
  - collide_index holds until the next REPORT with hit=1.
- Reset mid-scan: immediate return to the reset state.

Optional Feature:
- Macro: COLLISION_COUNT_EN.
- Defined:
  - Adds output collision_count [7:0], reset 0.
  - Increments by 1 on each REPORT with hit=1; saturates at 255.
  - Cleared only by reset, not by abort.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, obstacle_count=1, table[0]=(100,100), table[1]=(300,300), ball=(110,105), pulse frame_start -> obs_addr 0,1 read; sprite_collision=1 exactly 5 cycles after frame_start; collide_index=0; finish_line_reached=0.
- Ball=(92,100), obstacle (100,100) -> no collision (edge touch). Ball=(93,100) -> sprite_collision=1.
- obstacle_count=0, ball_x=592 -> no reads; finish_line_reached=1 one cycle after frame_start. Ball_x=591 -> no pulse.
- ball_x=595 overlapping table[2]=(590,200) with obstacle_count=2, ball_y=205 -> sprite_collision=1, collide_index=2, finish_line_reached=0.
- Assert abort during the 3rd CHECK of a 6-obstacle scan -> IDLE next edge, no pulses, busy=0. A second frame_start during the scan is ignored (single REPORT).
- With COLLISION_COUNT_EN: 300 colliding frames -> collision_count=255. Abort leaves it unchanged; reset clears it to 0.
